// File: rtl/multi_bbox_tracker.sv
// rtl/multi_bbox_tracker.sv - N-channel run-filtered bounding-box tracker with snapshot message writer
module multi_bbox_tracker #(
  parameter int NUM_CH   = 4,
  parameter int IMAGE_W  = 640,
  parameter int IMAGE_H  = 480,
  parameter int COORD_W  = 11,
  parameter int MIN_RUN  = 4,
  parameter int PCOUNT_W = 20
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        pix_valid,
  input  logic                        pix_sop,
  input  logic                        pix_eop,
  input  logic                        pix_is_video,
  input  logic [NUM_CH-1:0]           pix_mask,
  input  logic [7:0]                  cfg_interval,
  input  logic [NUM_CH-1:0]           cfg_ch_en,
  output logic [NUM_CH*COORD_W-1:0]   box_xmin,
  output logic [NUM_CH*COORD_W-1:0]   box_xmax,
  output logic [NUM_CH*COORD_W-1:0]   box_ymin,
  output logic [NUM_CH*COORD_W-1:0]   box_ymax,
  output logic [NUM_CH-1:0]           box_found,
  output logic [31:0]                 msg_data,
  output logic                        msg_valid,
  input  logic                        msg_ready,
  output logic                        frame_drop
);

  localparam logic [COORD_W-1:0] X_LAST  = COORD_W'(IMAGE_W - 1);
  localparam logic [COORD_W-1:0] Y_END   = COORD_W'(IMAGE_H);
  localparam logic [3:0]         RUN_MAX = 4'(MIN_RUN);

  typedef enum logic [2:0] {IDLE, HDR, XW, YW, CW} state_t;

  logic [COORD_W-1:0]  x, y;
  logic                video;
  logic [3:0]          run       [NUM_CH];
  logic [3:0]          run_nxt   [NUM_CH];
  logic [NUM_CH-1:0]   qual;
  logic [COORD_W-1:0]  acc_xmin  [NUM_CH], acc_xmax [NUM_CH], acc_ymin [NUM_CH], acc_ymax [NUM_CH];
  logic [COORD_W-1:0]  nxt_xmin  [NUM_CH], nxt_xmax [NUM_CH], nxt_ymin [NUM_CH], nxt_ymax [NUM_CH];
  logic [COORD_W-1:0]  lat_xmin  [NUM_CH], lat_xmax [NUM_CH], lat_ymin [NUM_CH], lat_ymax [NUM_CH];
  logic [PCOUNT_W-1:0] acc_cnt   [NUM_CH], nxt_cnt  [NUM_CH];
  logic [NUM_CH-1:0]   lat_found;
  logic [COORD_W-1:0]  snap_xmin [NUM_CH], snap_xmax [NUM_CH], snap_ymin [NUM_CH], snap_ymax [NUM_CH];
  logic [PCOUNT_W-1:0] snap_cnt  [NUM_CH];
  logic [NUM_CH-1:0]   snap_found, snap_en;
  logic [15:0]         frame_seq, snap_seq;
  logic [7:0]          fcnt;
  state_t              state;
  logic [2:0]          ch, first_ch, nxt_ch;
  logic                first_any, nxt_any;
  logic [COORD_W-1:0]  sel_xmin, sel_xmax, sel_ymin, sel_ymax;
  logic [PCOUNT_W-1:0] sel_cnt;
  logic                sel_found;

  wire pix_beat  = pix_valid & ~pix_sop;
  wire sop_beat  = pix_valid & pix_sop;
  wire in_frame  = (y < Y_END);
  wire eop_video = pix_beat & pix_eop & video;
  wire snap_req  = eop_video & (fcnt == 8'd0);

  // Run filter and accumulator next-state; the eop pixel itself is included in the latched box
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (!pix_mask[i])           run_nxt[i] = 4'd0;
      else if (x == '0)           run_nxt[i] = 4'd1;
      else if (run[i] >= RUN_MAX) run_nxt[i] = RUN_MAX;
      else                        run_nxt[i] = run[i] + 4'd1;
      qual[i]     = pix_beat & in_frame & (run_nxt[i] >= RUN_MAX);
      nxt_xmin[i] = acc_xmin[i];
      nxt_xmax[i] = acc_xmax[i];
      nxt_ymin[i] = acc_ymin[i];
      nxt_ymax[i] = acc_ymax[i];
      nxt_cnt[i]  = acc_cnt[i];
      if (qual[i]) begin
        if (x < acc_xmin[i]) nxt_xmin[i] = x;
        if (x > acc_xmax[i]) nxt_xmax[i] = x;
        if (y < acc_ymin[i]) nxt_ymin[i] = y;
        if (y > acc_ymax[i]) nxt_ymax[i] = y;
        if (!(&acc_cnt[i])) nxt_cnt[i] = acc_cnt[i] + 1'b1;
      end
      lat_found[i] = (nxt_cnt[i] != '0);
      lat_xmin[i]  = lat_found[i] ? nxt_xmin[i] : '0;
      lat_xmax[i]  = lat_found[i] ? nxt_xmax[i] : '0;
      lat_ymin[i]  = lat_found[i] ? nxt_ymin[i] : '0;
      lat_ymax[i]  = lat_found[i] ? nxt_ymax[i] : '0;
    end
  end

  // Channel selection for the writer: first enabled, next enabled after ch, and snapshot mux
  always_comb begin
    first_any = 1'b0;
    first_ch  = '0;
    nxt_any   = 1'b0;
    nxt_ch    = '0;
    sel_xmin  = '0;
    sel_xmax  = '0;
    sel_ymin  = '0;
    sel_ymax  = '0;
    sel_cnt   = '0;
    sel_found = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (cfg_ch_en[i]) begin
        first_any = 1'b1;
        first_ch  = 3'(i);
      end
      if (snap_en[i] && (3'(i) > ch)) begin
        nxt_any = 1'b1;
        nxt_ch  = 3'(i);
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch == 3'(i)) begin
        sel_xmin  = snap_xmin[i];
        sel_xmax  = snap_xmax[i];
        sel_ymin  = snap_ymin[i];
        sel_ymax  = snap_ymax[i];
        sel_cnt   = snap_cnt[i];
        sel_found = snap_found[i];
      end
    end
  end

  // Pixel coordinate tracking; y saturates at IMAGE_H so overlong frames stop accumulating
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x     <= '0;
      y     <= '0;
      video <= 1'b0;
    end else if (sop_beat) begin
      x     <= '0;
      y     <= '0;
      video <= pix_is_video;
    end else if (pix_beat) begin
      if (x == X_LAST) begin
        x <= '0;
        if (y < Y_END) y <= y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  // Run counters and per-frame accumulators, cleared at every packet start
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        run[i]      <= '0;
        acc_xmin[i] <= '1;
        acc_xmax[i] <= '0;
        acc_ymin[i] <= '1;
        acc_ymax[i] <= '0;
        acc_cnt[i]  <= '0;
      end
    end else if (sop_beat) begin
      for (int i = 0; i < NUM_CH; i++) begin
        run[i]      <= '0;
        acc_xmin[i] <= '1;
        acc_xmax[i] <= '0;
        acc_ymin[i] <= '1;
        acc_ymax[i] <= '0;
        acc_cnt[i]  <= '0;
      end
    end else if (pix_beat && in_frame) begin
      for (int i = 0; i < NUM_CH; i++) begin
        run[i]      <= run_nxt[i];
        acc_xmin[i] <= nxt_xmin[i];
        acc_xmax[i] <= nxt_xmax[i];
        acc_ymin[i] <= nxt_ymin[i];
        acc_ymax[i] <= nxt_ymax[i];
        acc_cnt[i]  <= nxt_cnt[i];
      end
    end
  end

  // End-of-video-frame latch, frame counter and private snapshot for the writer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      box_xmin   <= '0;
      box_xmax   <= '0;
      box_ymin   <= '0;
      box_ymax   <= '0;
      box_found  <= '0;
      frame_seq  <= '0;
      snap_seq   <= '0;
      fcnt       <= '0;
      frame_drop <= 1'b0;
      snap_found <= '0;
      snap_en    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        snap_xmin[i] <= '0;
        snap_xmax[i] <= '0;
        snap_ymin[i] <= '0;
        snap_ymax[i] <= '0;
        snap_cnt[i]  <= '0;
      end
    end else begin
      frame_drop <= 1'b0;
      if (eop_video) begin
        frame_seq <= frame_seq + 16'd1;
        box_found <= lat_found;
        for (int i = 0; i < NUM_CH; i++) begin
          box_xmin[i*COORD_W +: COORD_W] <= lat_xmin[i];
          box_xmax[i*COORD_W +: COORD_W] <= lat_xmax[i];
          box_ymin[i*COORD_W +: COORD_W] <= lat_ymin[i];
          box_ymax[i*COORD_W +: COORD_W] <= lat_ymax[i];
        end
        fcnt <= (fcnt == 8'd0) ? cfg_interval : fcnt - 8'd1;
      end
      if (snap_req && state != IDLE) begin
        frame_drop <= 1'b1;
      end else if (snap_req) begin
        snap_seq   <= frame_seq + 16'd1;
        snap_en    <= cfg_ch_en;
        snap_found <= lat_found;
        for (int i = 0; i < NUM_CH; i++) begin
          snap_xmin[i] <= lat_xmin[i];
          snap_xmax[i] <= lat_xmax[i];
          snap_ymin[i] <= lat_ymin[i];
          snap_ymax[i] <= lat_ymax[i];
          snap_cnt[i]  <= nxt_cnt[i];
        end
      end
    end
  end

  // Message writer; word registers advance only on an accepted beat so data holds during stalls
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      ch        <= '0;
      msg_valid <= 1'b0;
      msg_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (snap_req && first_any) begin
            state     <= HDR;
            ch        <= first_ch;
            msg_valid <= 1'b1;
            msg_data  <= {8'h42, 8'(first_ch), frame_seq + 16'd1};
          end
        end
        HDR: if (msg_ready) begin
          state    <= XW;
          msg_data <= {16'(sel_xmin), 16'(sel_xmax)};
        end
        XW: if (msg_ready) begin
          state    <= YW;
          msg_data <= {16'(sel_ymin), 16'(sel_ymax)};
        end
        YW: if (msg_ready) begin
          state    <= CW;
          msg_data <= {sel_found, 31'(sel_cnt)};
        end
        CW: if (msg_ready) begin
          if (nxt_any) begin
            state    <= HDR;
            ch       <= nxt_ch;
            msg_data <= {8'h42, 8'(nxt_ch), snap_seq};
          end else begin
            state     <= IDLE;
            msg_valid <= 1'b0;
            msg_data  <= '0;
          end
        end
        default: begin
          state     <= IDLE;
          msg_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multi_bbox_tracker.sv
// tb/tb_multi_bbox_tracker.sv - directed self-checking bench for multi_bbox_tracker
module tb_multi_bbox_tracker;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pix_valid = 1'b0, pix_sop = 1'b0, pix_eop = 1'b0, pix_is_video = 1'b0;
  logic [3:0]  pix_mask = '0;
  logic [7:0]  cfg_interval = '0;
  logic [3:0]  cfg_ch_en = '0;
  logic [43:0] box_xmin, box_xmax, box_ymin, box_ymax;
  logic [3:0]  box_found;
  logic [31:0] msg_data;
  logic        msg_valid;
  logic        msg_ready = 1'b1;
  logic        frame_drop;

  int vectors = 0;
  int miscompares = 0;
  int ready_mode = 0;
  logic [31:0] words[$];
  int drop_cnt = 0, stall_seen = 0, stall_bad = 0;
  logic prev_stall = 1'b0;
  logic [31:0] prev_data = '0;

  multi_bbox_tracker dut (
    .clk(clk), .reset_n(reset_n), .pix_valid(pix_valid), .pix_sop(pix_sop), .pix_eop(pix_eop),
    .pix_is_video(pix_is_video), .pix_mask(pix_mask), .cfg_interval(cfg_interval), .cfg_ch_en(cfg_ch_en),
    .box_xmin(box_xmin), .box_xmax(box_xmax), .box_ymin(box_ymin), .box_ymax(box_ymax),
    .box_found(box_found), .msg_data(msg_data), .msg_valid(msg_valid), .msg_ready(msg_ready),
    .frame_drop(frame_drop));

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk); #1;
    if (ready_mode == 0) msg_ready = 1'b1;
    else if (ready_mode == 1) msg_ready = ~msg_ready;
  end

  initial forever begin
    @(negedge clk);
    if (msg_valid && msg_ready) words.push_back(msg_data);
    if (frame_drop) drop_cnt++;
    if (prev_stall) begin
      stall_seen++;
      if (!(msg_valid && msg_data == prev_data)) stall_bad++;
    end
    prev_stall = msg_valid && !msg_ready;
    prev_data  = msg_data;
  end

  function automatic logic [3:0] mask_fn(input int x, input int y, input int mode);
    logic [3:0] m;
    m = '0;
    case (mode)
      1: m[0] = (x >= 100 && x <= 199 && y >= 50 && y <= 59);
      2: begin
        m[0] = (y == 1 && x >= 10 && x <= 12) || (y == 2 && x >= 20 && x <= 22) ||
               (y == 3 && x >= 638) || (y == 4 && x <= 1);
        m[1] = (y == 3 && x >= 5 && x <= 8);
      end
      4: begin
        m[1] = (x >= 2 && x <= 9);
        m[3] = (x <= 15);
      end
      6: m[1] = (x <= 15);
      default: m = '0;
    endcase
    return m;
  endfunction

  task automatic frame(input logic vid, input int npix, input int mode);
    pix_valid = 1'b1; pix_sop = 1'b1; pix_eop = 1'b0; pix_is_video = vid; pix_mask = '0;
    @(posedge clk); #1;
    pix_sop = 1'b0; pix_is_video = 1'b0;
    for (int p = 0; p < npix; p++) begin
      pix_mask = mask_fn(p % 640, p / 640, mode);
      pix_eop  = (p == npix - 1);
      @(posedge clk); #1;
    end
    pix_valid = 1'b0; pix_eop = 1'b0; pix_mask = '0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; pix_valid = 1'b0; pix_sop = 1'b0; pix_eop = 1'b0; pix_mask = '0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic wait_words(input int n);
    for (int i = 0; i < 200 && words.size() < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #3;
    vectors++; if (msg_valid !== 1'b0) begin miscompares++; $display("FAIL reset_msg_valid got %b expected 0", msg_valid); end
    vectors++; if (msg_data !== 32'h0) begin miscompares++; $display("FAIL reset_msg_data got %h expected 0", msg_data); end
    vectors++; if (frame_drop !== 1'b0) begin miscompares++; $display("FAIL reset_frame_drop got %b expected 0", frame_drop); end
    vectors++; if (box_found !== 4'h0) begin miscompares++; $display("FAIL reset_box_found got %h expected 0", box_found); end
    vectors++; if (box_xmin !== 44'h0 || box_xmax !== 44'h0) begin miscompares++; $display("FAIL reset_box_x got %h/%h expected 0", box_xmin, box_xmax); end
    vectors++; if (box_ymin !== 44'h0 || box_ymax !== 44'h0) begin miscompares++; $display("FAIL reset_box_y got %h/%h expected 0", box_ymin, box_ymax); end
    do_reset();
  endtask

  task automatic test_rect_box();
    int base;
    do_reset();
    cfg_interval = 8'd0; cfg_ch_en = 4'b0001; ready_mode = 0;
    base = words.size();
    frame(1'b1, 60 * 640, 1);
    wait_words(base + 4);
    vectors++; if (box_xmin[10:0] !== 11'd103 || box_xmax[10:0] !== 11'd199) begin miscompares++; $display("FAIL rect_box_x got %0d,%0d expected 103,199", box_xmin[10:0], box_xmax[10:0]); end
    vectors++; if (box_ymin[10:0] !== 11'd50 || box_ymax[10:0] !== 11'd59) begin miscompares++; $display("FAIL rect_box_y got %0d,%0d expected 50,59", box_ymin[10:0], box_ymax[10:0]); end
    vectors++; if (box_found !== 4'b0001) begin miscompares++; $display("FAIL rect_found got %b expected 0001", box_found); end
    vectors++; if (words.size() - base !== 4) begin miscompares++; $display("FAIL rect_word_count got %0d expected 4", words.size() - base); end
    else begin
      vectors++; if (words[base] !== 32'h4200_0001) begin miscompares++; $display("FAIL rect_hdr got %h expected 42000001", words[base]); end
      vectors++; if (words[base+1] !== 32'h0067_00C7) begin miscompares++; $display("FAIL rect_xw got %h expected 006700c7", words[base+1]); end
      vectors++; if (words[base+2] !== 32'h0032_003B) begin miscompares++; $display("FAIL rect_yw got %h expected 0032003b", words[base+2]); end
      vectors++; if (words[base+3] !== 32'h8000_03CA) begin miscompares++; $display("FAIL rect_cw got %h expected 800003ca", words[base+3]); end
    end
  endtask

  task automatic test_run_filter();
    int base;
    do_reset();
    cfg_interval = 8'd0; cfg_ch_en = 4'b0000; ready_mode = 0;
    base = words.size();
    frame(1'b1, 5 * 640, 2);
    repeat (10) begin @(posedge clk); #1; end
    vectors++; if (box_found !== 4'b0010) begin miscompares++; $display("FAIL filter_found got %b expected 0010", box_found); end
    vectors++; if (box_xmin[10:0] !== 11'd0 || box_xmax[10:0] !== 11'd0 || box_ymin[10:0] !== 11'd0 || box_ymax[10:0] !== 11'd0) begin
      miscompares++; $display("FAIL filter_box0 got %0d,%0d,%0d,%0d expected 0,0,0,0", box_xmin[10:0], box_xmax[10:0], box_ymin[10:0], box_ymax[10:0]); end
    vectors++; if (box_xmin[21:11] !== 11'd8 || box_xmax[21:11] !== 11'd8) begin miscompares++; $display("FAIL filter_box1_x got %0d,%0d expected 8,8", box_xmin[21:11], box_xmax[21:11]); end
    vectors++; if (box_ymin[21:11] !== 11'd3 || box_ymax[21:11] !== 11'd3) begin miscompares++; $display("FAIL filter_box1_y got %0d,%0d expected 3,3", box_ymin[21:11], box_ymax[21:11]); end
    vectors++; if (words.size() - base !== 0 || msg_valid !== 1'b0) begin miscompares++; $display("FAIL filter_no_msg got %0d words valid %b expected 0 words valid 0", words.size() - base, msg_valid); end
  endtask

  task automatic test_interval();
    int base, dbase, exp_msgs;
    do_reset();
    cfg_interval = 8'd2; cfg_ch_en = 4'b0001; ready_mode = 0;
    base = words.size(); dbase = drop_cnt; exp_msgs = 0;
    for (int f = 1; f <= 7; f++) begin
      frame(1'b1, 16, 4);
      frame(1'b0, 16, 6);
      repeat (4) begin @(posedge clk); #1; end
      if (f == 1) begin
        vectors++; if (box_xmin[21:11] !== 11'd5) begin miscompares++; $display("FAIL nonvideo_keeps_box got %0d expected 5", box_xmin[21:11]); end
      end
      if (f == 1 || f == 4 || f == 7) exp_msgs++;
      vectors++; if (words.size() - base !== 4 * exp_msgs) begin miscompares++; $display("FAIL interval_words_f%0d got %0d expected %0d", f, words.size() - base, 4 * exp_msgs); end
      else if (f == 1 || f == 4 || f == 7) begin
        vectors++; if (words[base + 4*exp_msgs - 4] !== {8'h42, 8'h00, 16'(f)}) begin miscompares++; $display("FAIL interval_hdr_f%0d got %h expected %h", f, words[base + 4*exp_msgs - 4], {8'h42, 8'h00, 16'(f)}); end
      end
    end
    vectors++; if (drop_cnt - dbase !== 0) begin miscompares++; $display("FAIL interval_drops got %0d expected 0", drop_cnt - dbase); end
  endtask

  task automatic test_stall_channels();
    int base, sbase, bbase;
    logic [31:0] exp [8];
    exp = '{32'h4201_0001, 32'h0005_0009, 32'h0000_0000, 32'h8000_0005,
            32'h4203_0001, 32'h0003_000F, 32'h0000_0000, 32'h8000_000D};
    do_reset();
    cfg_interval = 8'd0; cfg_ch_en = 4'b1010; ready_mode = 1;
    base = words.size(); sbase = stall_seen; bbase = stall_bad;
    frame(1'b1, 16, 4);
    wait_words(base + 8);
    repeat (20) begin @(posedge clk); #1; end
    vectors++; if (words.size() - base !== 8) begin miscompares++; $display("FAIL stall_word_count got %0d expected 8", words.size() - base); end
    else begin
      for (int i = 0; i < 8; i++) begin
        vectors++; if (words[base+i] !== exp[i]) begin miscompares++; $display("FAIL stall_word%0d got %h expected %h", i, words[base+i], exp[i]); end
      end
    end
    vectors++; if (stall_bad - bbase !== 0) begin miscompares++; $display("FAIL stall_hold got %0d unstable cycles expected 0", stall_bad - bbase); end
    vectors++; if (stall_seen - sbase < 1) begin miscompares++; $display("FAIL stall_exercised got %0d stall cycles expected >=1", stall_seen - sbase); end
    ready_mode = 0;
  endtask

  task automatic test_frame_drop();
    int base, dbase;
    do_reset();
    cfg_interval = 8'd0; cfg_ch_en = 4'b0010; ready_mode = 2; msg_ready = 1'b0;
    base = words.size(); dbase = drop_cnt;
    frame(1'b1, 16, 4);
    frame(1'b1, 16, 6);
    repeat (3) begin @(posedge clk); #1; end
    vectors++; if (drop_cnt - dbase !== 1) begin miscompares++; $display("FAIL drop_pulses got %0d expected 1", drop_cnt - dbase); end
    vectors++; if (msg_valid !== 1'b1 || msg_data !== 32'h4201_0001) begin miscompares++; $display("FAIL drop_hdr_held got %b/%h expected 1/42010001", msg_valid, msg_data); end
    vectors++; if (box_xmin[21:11] !== 11'd3 || box_xmax[21:11] !== 11'd15) begin miscompares++; $display("FAIL drop_box_second got %0d,%0d expected 3,15", box_xmin[21:11], box_xmax[21:11]); end
    ready_mode = 0;
    wait_words(base + 4);
    repeat (5) begin @(posedge clk); #1; end
    vectors++; if (words.size() - base !== 4) begin miscompares++; $display("FAIL drop_word_count got %0d expected 4", words.size() - base); end
    else begin
      vectors++; if (words[base+1] !== 32'h0005_0009) begin miscompares++; $display("FAIL drop_xw got %h expected 00050009", words[base+1]); end
      vectors++; if (words[base+3] !== 32'h8000_0005) begin miscompares++; $display("FAIL drop_cw got %h expected 80000005", words[base+3]); end
    end
  endtask

  task automatic test_async_reset();
    int base;
    do_reset();
    cfg_interval = 8'd0; cfg_ch_en = 4'b0010; ready_mode = 2; msg_ready = 1'b0;
    frame(1'b1, 16, 4);
    @(posedge clk); #1;
    msg_ready = 1'b1;
    @(posedge clk); #1;
    msg_ready = 1'b0;
    vectors++; if (msg_valid !== 1'b1 || msg_data !== 32'h0005_0009) begin miscompares++; $display("FAIL areset_in_xw got %b/%h expected 1/00050009", msg_valid, msg_data); end
    reset_n = 1'b0;
    #1;
    vectors++; if (msg_valid !== 1'b0) begin miscompares++; $display("FAIL areset_valid_drop got %b expected 0", msg_valid); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    ready_mode = 0;
    base = words.size();
    frame(1'b1, 16, 4);
    wait_words(base + 4);
    vectors++; if (words.size() - base !== 4) begin miscompares++; $display("FAIL areset_word_count got %0d expected 4", words.size() - base); end
    else begin
      vectors++; if (words[base] !== 32'h4201_0001) begin miscompares++; $display("FAIL areset_hdr got %h expected 42010001", words[base]); end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_rect_box();
    test_run_filter();
    test_interval();
    test_stall_channels();
    test_frame_drop();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
